// File: rtl/vga_capture_if.sv
// Frame buffer write port of the VGA capture block.
interface vga_capture_if;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [23:0] wr_data;
  logic        frame_done;

  modport master (output wr_en, wr_addr, wr_data, frame_done);
  modport slave  (input  wr_en, wr_addr, wr_data, frame_done);
endinterface

// File: rtl/vga_capture.sv
// VGA timing receiver: recovers x/y from hsync/vsync, locks to the nominal
// frame geometry and writes a fixed window of pixels into a frame buffer.
module vga_capture #(
  parameter int unsigned H_TOTAL = 641,
  parameter int unsigned V_TOTAL = 481,
  parameter int unsigned WIN_X0  = 170,
  parameter int unsigned WIN_Y0  = 90,
  parameter int unsigned WIN_W   = 300,
  parameter int unsigned WIN_H   = 300
) (
  input  logic         VGA_CLK_IN,
  input  logic         i_rst_n,
  input  logic         i_hsync,
  input  logic         i_vsync,
  input  logic [7:0]   i_red,
  input  logic [7:0]   i_green,
  input  logic [7:0]   i_blue,
  output logic [9:0]   o_x,
  output logic [9:0]   o_y,
  output logic         o_locked,
  output logic         o_err,
  vga_capture_if.master fb
);

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_TOT     = 10'(H_TOTAL);
  localparam logic [9:0]  V_TOT     = 10'(V_TOTAL);
  localparam logic [9:0]  X_LO      = 10'(WIN_X0);
  localparam logic [9:0]  X_HI      = 10'(WIN_X0 + WIN_W);
  localparam logic [9:0]  Y_LO      = 10'(WIN_Y0);
  localparam logic [9:0]  Y_HI      = 10'(WIN_Y0 + WIN_H);
  localparam logic [16:0] ADDR_LAST = 17'(WIN_W * WIN_H - 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs1_q, vs1_q, hs1_prev_q, vs_ls_q;
  logic [23:0] rgb1_q;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [16:0] addr_q, addr_d;
  logic        ls, fs, line_bad, frame_bad, hs_miss, vs_miss, cap, err_d;
  logic [9:0]  x_out_q, y_out_q;
  logic        wr_en_q, done_q, err_q;
  logic [16:0] wr_addr_q;
  logic [23:0] wr_data_q;

  // Input stage: sample sync and colour from the pins.
  always_ff @(posedge VGA_CLK_IN or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      hs1_prev_q <= 1'b0;
      rgb1_q     <= '0;
    end else begin
      hs1_q      <= i_hsync;
      vs1_q      <= i_vsync;
      hs1_prev_q <= hs1_q;
      rgb1_q     <= {i_red, i_green, i_blue};
    end
  end

  assign ls = hs1_q & ~hs1_prev_q;
  assign fs = ls & vs1_q & ~vs_ls_q;

  // Coordinates of the pixel currently in stage 1 (x_q/y_q hold the previous one).
  always_comb begin
    x_d = (x_q == '1) ? x_q : x_q + 10'd1;
    if (ls) x_d = '0;
    y_d = y_q;
    if (ls) begin
      if (fs)              y_d = '0;
      else if (y_q != '1)  y_d = y_q + 10'd1;
    end
  end

  // Coordinate counters and vsync level remembered at each line start.
  always_ff @(posedge VGA_CLK_IN or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      vs_ls_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (ls) vs_ls_q <= vs1_q;
    end
  end

  assign line_bad  = ls && (x_q != H_LAST);
  assign frame_bad = fs && (y_q != V_LAST);
  assign hs_miss   = !ls && (x_d == H_TOT);
  assign vs_miss   = ls && !fs && (y_d == V_TOT);

  // Lock FSM: a violation on an fs cycle takes priority over locking.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      SEARCH: if (fs) state_d = ACQUIRE;
      ACQUIRE: begin
        if (line_bad || frame_bad) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end else if (fs) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad || hs_miss || vs_miss) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge VGA_CLK_IN or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= SEARCH;
    else          state_q <= state_d;
  end

  assign cap = (state_q == LOCKED) && (x_d >= X_LO) && (x_d < X_HI)
               && (y_d >= Y_LO) && (y_d < Y_HI);

  // Row-major write address: cleared at frame start, saturates at the last cell.
  always_comb begin
    addr_d = addr_q;
    if (fs)                              addr_d = '0;
    else if (cap && addr_q != ADDR_LAST) addr_d = addr_q + 17'd1;
  end

  // Output stage: everything aligned two clocks after the pins.
  always_ff @(posedge VGA_CLK_IN or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q    <= '0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      x_out_q   <= x_d;
      y_out_q   <= y_d;
      wr_en_q   <= cap;
      wr_addr_q <= addr_q;
      wr_data_q <= rgb1_q;
      done_q    <= cap && (addr_q == ADDR_LAST);
      err_q     <= err_d;
    end
  end

  assign o_x           = x_out_q;
  assign o_y           = y_out_q;
  assign o_locked      = (state_q == LOCKED);
  assign o_err         = err_q;
  assign fb.wr_en      = wr_en_q;
  assign fb.wr_addr    = wr_addr_q;
  assign fb.wr_data    = wr_data_q;
  assign fb.frame_done = done_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced frame geometry so whole frames fit a short run.
module tb_vga_capture;

  localparam int H    = 40;
  localparam int V    = 30;
  localparam int X0   = 10;
  localparam int Y0   = 5;
  localparam int WW   = 12;
  localparam int WH   = 8;
  localparam int HS   = 6;
  localparam int VS   = 2;
  localparam int LAST = WW * WH - 1;
  localparam int LOGN = 2048;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hs, vs;
  logic [7:0] r, g, b;
  logic [9:0] ox, oy;
  logic       locked, err;

  vga_capture_if fb();

  vga_capture #(
    .H_TOTAL(H), .V_TOTAL(V), .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(WW), .WIN_H(WH)
  ) dut (
    .VGA_CLK_IN(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_vsync(vs),
    .i_red(r), .i_green(g), .i_blue(b),
    .o_x(ox), .o_y(oy), .o_locked(locked), .o_err(err), .fb(fb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log filled by the monitor, checked by the driver after each frame.
  typedef struct packed {
    logic [16:0] addr;
    logic [23:0] data;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        done;
    int          t;
  } wlog_t;

  wlog_t wlog [LOGN];
  int    wr_cnt = 0, done_cnt = 0, err_cnt = 0, t_lock = -1000;
  logic  locked_prev = 1'b0;

  always @(negedge clk) begin
    if (fb.wr_en) begin
      if (wr_cnt < LOGN) wlog[wr_cnt] <= '{fb.wr_addr, fb.wr_data, ox, oy, fb.frame_done, cyc};
      wr_cnt <= wr_cnt + 1;
    end
    if (fb.frame_done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (locked && !locked_prev) t_lock <= cyc;
    locked_prev <= locked;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " o_x"}, ox, 0);
    chk({tag, " o_y"}, oy, 0);
    chk({tag, " o_locked"}, locked, 0);
    chk({tag, " o_err"}, err, 0);
    chk({tag, " wr_en"}, fb.wr_en, 0);
    chk({tag, " wr_addr"}, fb.wr_addr, 0);
    chk({tag, " wr_data"}, fb.wr_data, 0);
    chk({tag, " frame_done"}, fb.frame_done, 0);
  endtask

  function automatic logic [23:0] pix(input int x, input int y);
    if (x == X0 && y == Y0) return 24'h123456;
    return {8'(x), 8'(y), 8'hC3};
  endfunction

  typedef struct {
    int short_line;   // line driven one clock short, -1 none
    int extra_lines;  // lines appended past V without vsync
    int reset_line;   // line during which reset is held, -1 none
    int exp_writes;
    int exp_done;
    int exp_err;
    bit exp_locked;   // o_locked after the last pixel is driven
    bit exp_rise;     // o_locked rises two cycles after this frame's fs pixel
  } frame_t;

  frame_t tbl [12];

  task automatic drive_frame(input int idx, input frame_t f);
    int w0, d0, e0, t_first, t_fs, len, k, ex, ey;
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    t_first = -1000; t_fs = -1000;
    for (int l = 0; l < V + f.extra_lines; l++) begin
      len = (l == f.short_line) ? H - 1 : H;
      for (int c = 0; c < len; c++) begin
        @(posedge clk); #1;
        hs = (c < HS);
        vs = (l < VS);
        {r, g, b} = pix(c, l);
        if (l == 0 && c == 0) t_fs = cyc;
        if (l == Y0 && c == X0) t_first = cyc;
        if (l == f.reset_line && c == 0) begin
          #2 rst_n = 1'b0;
          #1 check_reset_outputs($sformatf("f%0d midframe reset", idx));
        end
        if (l == f.reset_line && c == len - 1) #2 rst_n = 1'b1;
      end
    end
    chk($sformatf("f%0d write count", idx), wr_cnt - w0, f.exp_writes);
    chk($sformatf("f%0d frame_done count", idx), done_cnt - d0, f.exp_done);
    chk($sformatf("f%0d err count", idx), err_cnt - e0, f.exp_err);
    chk($sformatf("f%0d o_locked", idx), locked, f.exp_locked);
    for (int i = w0; i < wr_cnt && i < LOGN; i++) begin
      k  = i - w0;
      ex = X0 + k % WW;
      ey = Y0 + k / WW;
      chk($sformatf("f%0d w%0d addr", idx, k), wlog[i].addr, k);
      chk($sformatf("f%0d w%0d data", idx, k), wlog[i].data, pix(ex, ey));
      chk($sformatf("f%0d w%0d o_x", idx, k), wlog[i].x, ex);
      chk($sformatf("f%0d w%0d o_y", idx, k), wlog[i].y, ey);
      chk($sformatf("f%0d w%0d frame_done", idx, k), wlog[i].done, (k == LAST));
      if (k == 0) chk($sformatf("f%0d first write latency", idx), wlog[i].t - t_first, 2);
    end
    if (f.exp_rise) chk($sformatf("f%0d lock latency", idx), t_lock - t_fs, 2);
  endtask

  initial begin
    rst_n = 1'b0;
    hs = 1'b0; vs = 1'b0; r = '0; g = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("power-on reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    //          short extra rst  wr  done err lock rise
    tbl[0]  = '{-1,   0,   -1,   0,  0,   0,  0,   0};  // fs 1: ACQUIRE
    tbl[1]  = '{-1,   0,   -1,   96, 1,   0,  1,   1};  // fs 2: LOCKED
    tbl[2]  = '{-1,   0,   -1,   96, 1,   0,  1,   0};
    tbl[3]  = '{10,   0,   -1,   72, 0,   1,  0,   0};  // short line, err at next ls
    tbl[4]  = '{-1,   0,   -1,   0,  0,   0,  0,   0};
    tbl[5]  = '{-1,   0,   -1,   96, 1,   0,  1,   1};  // relock
    tbl[6]  = '{-1,   3,   -1,   96, 1,   1,  0,   0};  // missing vsync at y == V
    tbl[7]  = '{-1,   0,   -1,   0,  0,   0,  0,   0};
    tbl[8]  = '{-1,   0,   -1,   96, 1,   0,  1,   1};
    tbl[9]  = '{-1,   0,    9,   48, 0,   0,  0,   0};  // reset mid-window
    tbl[10] = '{-1,   0,   -1,   0,  0,   0,  0,   0};
    tbl[11] = '{-1,   0,   -1,   96, 1,   0,  1,   1};

    for (int i = 0; i < 12; i++) drive_frame(i, tbl[i]);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
